// File: rtl/game_engine_gen.sv
// Game sequencer for an N-LED GRB strip: PLAY / FLASH / WIN / LOSE with lives,
// level tracking, blink timing and refresh requests toward the strip driver.
module game_engine_gen #(
    parameter int unsigned NUM_LEDS   = 5,
    parameter int unsigned COLOR_W    = 24,
    parameter int unsigned LVL_W      = 3,
    parameter int unsigned MAX_LVL    = 5,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned FLASH_LEN  = 268435456,
    parameter int unsigned BLINK_HALF = 16777216,
    parameter logic [COLOR_W-1:0] WIN_COLOR  = COLOR_W'(24'hFF0000),
    parameter logic [COLOR_W-1:0] LOSE_COLOR = COLOR_W'(24'h00FF00)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go_i,
    input  logic                            hit_i,
    input  logic                            cycle_i,
    input  logic [NUM_LEDS*COLOR_W-1:0]     grb_in_i,
    output logic [NUM_LEDS*COLOR_W-1:0]     grb_seq_o,
    output logic                            refresh_o,
    output logic                            run_o,
    output logic [LVL_W-1:0]                lvl_o,
    output logic [$clog2(LIVES+1)-1:0]      lives_o,
    output logic [1:0]                      state_o
);

    localparam int unsigned DATA_W  = NUM_LEDS * COLOR_W;
    localparam int unsigned LIVES_W = $clog2(LIVES + 1);
    localparam int unsigned FCNT_W  = $clog2(FLASH_LEN);
    localparam int unsigned BCNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_FLASH = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LVL_W-1:0]    lvl_q,   lvl_d;
    logic [LIVES_W-1:0]  lives_q, lives_d;
    logic [FCNT_W-1:0]   fcnt_q,  fcnt_d;
    logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;
    logic                ph_q,    ph_d;
    logic                chg_q,   chg_d;
    logic                go_q;

    logic go_rise;
    logic flash_end;
    logic blinking;
    logic blink_tick;

    assign go_rise    = go_i & ~go_q;
    assign flash_end  = (state_q == ST_FLASH) && (fcnt_q == FCNT_W'(FLASH_LEN - 1));
    assign blinking   = (state_q == ST_FLASH) || (state_q == ST_WIN);
    assign blink_tick = blinking && (bcnt_q == BCNT_W'(BLINK_HALF - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PLAY;
            lvl_q   <= '0;
            lives_q <= LIVES_W'(LIVES);
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            ph_q    <= 1'b0;
            chg_q   <= 1'b0;
            // Follow the button through reset so a press held across it never reads as an edge.
            go_q    <= go_i;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            lives_q <= lives_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
            ph_q    <= ph_d;
            chg_q   <= chg_d;
            go_q    <= go_i;
        end
    end

    // Next-state, level/lives and timer updates
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        lives_d = lives_q;
        fcnt_d  = '0;
        bcnt_d  = '0;
        ph_d    = 1'b0;
        chg_d   = 1'b0;

        unique case (state_q)
            ST_PLAY: begin
                if (lvl_q == LVL_W'(MAX_LVL)) begin
                    state_d = ST_WIN;
                end else if (go_rise) begin
                    state_d = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (flash_end) begin
                    if (hit_i) begin
                        if (lvl_q != LVL_W'(MAX_LVL)) begin
                            lvl_d = lvl_q + LVL_W'(1);
                        end
                        state_d = ST_PLAY;
                    end else if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_PLAY;
                    end else begin
                        lives_d = '0;
                        state_d = ST_LOSE;
                    end
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            ST_WIN, ST_LOSE: begin
                if (go_rise) begin
                    lvl_d   = '0;
                    lives_d = LIVES_W'(LIVES);
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_PLAY;
        endcase

        chg_d = (state_d != state_q);

        // Blink restarts in the "on" phase whenever a blinking state is entered.
        if (blinking && !chg_d) begin
            if (blink_tick) begin
                bcnt_d = '0;
                ph_d   = ~ph_q;
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
                ph_d   = ph_q;
            end
        end
    end

    // Frame selection toward the strip driver
    always_comb begin
        grb_seq_o = grb_in_i;
        unique case (state_q)
            ST_PLAY:  grb_seq_o = grb_in_i;
            ST_FLASH: grb_seq_o = ph_q ? '0 : grb_in_i;
            ST_WIN:   grb_seq_o = ph_q ? '0 : DATA_W'({NUM_LEDS{WIN_COLOR}});
            ST_LOSE:  grb_seq_o = DATA_W'({NUM_LEDS{LOSE_COLOR}});
            default:  grb_seq_o = grb_in_i;
        endcase
    end

    assign refresh_o = cycle_i | blink_tick | chg_q;
    assign run_o     = (state_q == ST_PLAY);
    assign lvl_o     = lvl_q;
    assign lives_o   = lives_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_game_engine_gen.sv
// Scoreboard bench for game_engine_gen: a timeline-based reference model pushes
// expected outputs each cycle; they are popped and compared mid-cycle.
module tb_game_engine_gen;

    localparam int unsigned NL    = 2;
    localparam int unsigned CW    = 24;
    localparam int unsigned DW    = NL * CW;
    localparam int unsigned LVL_W = 3;
    localparam int unsigned MAXL  = 2;
    localparam int unsigned LIV   = 2;
    localparam int unsigned LV_W  = $clog2(LIV + 1);
    localparam int unsigned FL    = 8;
    localparam int unsigned BH    = 2;
    localparam logic [DW-1:0] WIN_FRAME  = 48'hFF0000_FF0000;
    localparam logic [DW-1:0] LOSE_FRAME = 48'h00FF00_00FF00;
    localparam logic [DW-1:0] PATTERN    = 48'h123456_abcdef;

    logic             clk = 1'b0;
    logic             reset, go, hit, cycle;
    logic [DW-1:0]    grb_in, grb_seq;
    logic             refresh, run;
    logic [LVL_W-1:0] lvl;
    logic [LV_W-1:0]  lives;
    logic [1:0]       state;

    always #5 clk = ~clk;

    game_engine_gen #(
        .NUM_LEDS  (NL),
        .COLOR_W   (CW),
        .LVL_W     (LVL_W),
        .MAX_LVL   (MAXL),
        .LIVES     (LIV),
        .FLASH_LEN (FL),
        .BLINK_HALF(BH),
        .WIN_COLOR (24'hFF0000),
        .LOSE_COLOR(24'h00FF00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go_i     (go),
        .hit_i    (hit),
        .cycle_i  (cycle),
        .grb_in_i (grb_in),
        .grb_seq_o(grb_seq),
        .refresh_o(refresh),
        .run_o    (run),
        .lvl_o    (lvl),
        .lives_o  (lives),
        .state_o  (state)
    );

    typedef struct packed {
        logic [1:0]       st;
        logic [LVL_W-1:0] lvl;
        logic [LV_W-1:0]  lives;
        logic             run;
        logic [DW-1:0]    grb;
        logic             refresh;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: state plus cycles elapsed since that state was entered.
    int m_st, m_lvl, m_lives, m_el;
    bit m_chg, m_go;
    int flash_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input logic c);
        exp_t e;
        bit   blink, ph, tick;
        blink = (m_st == 1) || (m_st == 2);
        ph    = blink && (((m_el / BH) % 2) == 1);
        tick  = blink && ((m_el % BH) == BH - 1);
        e.st      = 2'(m_st);
        e.lvl     = LVL_W'(m_lvl);
        e.lives   = LV_W'(m_lives);
        e.run     = (m_st == 0);
        case (m_st)
            0:       e.grb = grb_in;
            1:       e.grb = ph ? '0 : grb_in;
            2:       e.grb = ph ? '0 : WIN_FRAME;
            default: e.grb = LOSE_FRAME;
        endcase
        e.refresh = c | tick | m_chg;
        return e;
    endfunction

    task automatic model_clk(input logic r, input logic g, input logic h);
        int  nxt;
        bit  rise;
        if (r) begin
            m_st = 0; m_lvl = 0; m_lives = LIV; m_el = 0; m_chg = 0; m_go = g;
        end else begin
            rise = g && !m_go;
            nxt  = m_st;
            case (m_st)
                0: if (m_lvl == MAXL) nxt = 2; else if (rise) nxt = 1;
                1: if (m_el == FL - 1) begin
                       if (h) begin m_lvl++; nxt = 0; end
                       else if (m_lives > 1) begin m_lives--; nxt = 0; end
                       else begin m_lives = 0; nxt = 3; end
                   end
                default: if (rise) begin m_lvl = 0; m_lives = LIV; nxt = 0; end
            endcase
            m_chg = (nxt != m_st);
            m_el  = (nxt != m_st) ? 0 : m_el + 1;
            m_st  = nxt;
            m_go  = g;
        end
    endtask

    task automatic step(input logic r, input logic g, input logic h, input logic c, input bit chk);
        exp_t e;
        reset = r; go = g; hit = h; cycle = c;
        if (chk) sb_q.push_back(model_out(c));
        @(negedge clk);
        if (chk) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 64'(1), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check_eq("state",   64'(state),   64'(e.st));
                check_eq("lvl",     64'(lvl),     64'(e.lvl));
                check_eq("lives",   64'(lives),   64'(e.lives));
                check_eq("run",     64'(run),     64'(e.run));
                check_eq("grb_seq", 64'(grb_seq), 64'(e.grb));
                check_eq("refresh", 64'(refresh), 64'(e.refresh));
            end
        end
        @(posedge clk);
        model_clk(r, g, h);
        #1;
        if (state == 2'd1) flash_cnt++;
    endtask

    function automatic logic rnd_cycle();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic run_n(input int n, input logic g, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, g, h, rnd_cycle(), 1'b1);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; hit = 1'b0; cycle = 1'b0; grb_in = PATTERN;
        m_st = 0; m_lvl = 0; m_lives = LIV; m_el = 0; m_chg = 0; m_go = 0;
        flash_cnt = 0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_state",   64'(state),   64'(0));
        check_eq("rst_lvl",     64'(lvl),     64'(0));
        check_eq("rst_lives",   64'(lives),   64'(2));
        check_eq("rst_run",     64'(run),     64'(1));
        check_eq("rst_grb",     64'(grb_seq), 64'(PATTERN));
        check_eq("rst_refresh0", 64'(refresh), 64'(0));
        cycle = 1'b1; #1;
        check_eq("rst_refresh1", 64'(refresh), 64'(1));

        // Held press: one round, no second round while still held.
        flash_cnt = 0;
        run_n(20, 1'b1, 1'b1);
        check_eq("r1_flash_len", 64'(flash_cnt), 64'(FL));
        check_eq("r1_lvl",       64'(lvl),       64'(1));
        check_eq("r1_held_play", 64'(state),     64'(0));
        run_n(2, 1'b0, 1'b1);

        // Second hit reaches MAX_LVL then WIN.
        flash_cnt = 0;
        run_n(1, 1'b1, 1'b1);
        run_n(11, 1'b0, 1'b1);
        check_eq("r2_flash_len", 64'(flash_cnt), 64'(FL));
        check_eq("win_state",    64'(state),     64'(2));
        check_eq("win_lvl",      64'(lvl),       64'(2));
        run_n(6, 1'b0, 1'b0);
        run_n(1, 1'b1, 1'b0);
        check_eq("win_exit_state", 64'(state), 64'(0));
        check_eq("win_exit_lvl",   64'(lvl),   64'(0));
        check_eq("win_exit_lives", 64'(lives), 64'(2));
        run_n(1, 1'b0, 1'b0);

        // Two misses: keep level, lose a life, then LOSE.
        run_n(1, 1'b1, 1'b0);
        run_n(10, 1'b0, 1'b0);
        check_eq("miss1_lives", 64'(lives), 64'(1));
        check_eq("miss1_state", 64'(state), 64'(0));
        run_n(1, 1'b1, 1'b0);
        run_n(10, 1'b0, 1'b0);
        check_eq("lose_state", 64'(state), 64'(3));
        check_eq("lose_lives", 64'(lives), 64'(0));
        check_eq("lose_grb",   64'(grb_seq), 64'(LOSE_FRAME));
        run_n(4, 1'b0, 1'b0);
        run_n(1, 1'b1, 1'b0);
        check_eq("lose_exit_lives", 64'(lives), 64'(2));
        run_n(1, 1'b0, 1'b0);

        // go pulse inside FLASH is ignored; hit toggles, end-cycle value (0) counts.
        flash_cnt = 0;
        step(1'b0, 1'b1, 1'b0, rnd_cycle(), 1'b1);
        for (int i = 1; i < 12; i++)
            step(1'b0, (i == 4), (i % 2 == 1), rnd_cycle(), 1'b1);
        check_eq("gopulse_flash_len", 64'(flash_cnt), 64'(FL));
        check_eq("toggle_lives",      64'(lives),     64'(1));
        check_eq("toggle_lvl",        64'(lvl),       64'(0));

        // Reset at FLASH cycle 5.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("pre_rst_flash", 64'(state), 64'(1));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("mid_rst_state",   64'(state),   64'(0));
        check_eq("mid_rst_lives",   64'(lives),   64'(2));
        check_eq("mid_rst_lvl",     64'(lvl),     64'(0));
        check_eq("mid_rst_no_chg",  64'(refresh), 64'(0));
        run_n(3, 1'b0, 1'b0);

        // go held high through reset must not start a round.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_n(5, 1'b1, 1'b0);
        check_eq("held_go_no_round", 64'(state), 64'(0));

        check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
